// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan driver.
//   SEG_0..SEG_F : active-high {g,f,e,d,c,b,a} patterns for hex digits
//   SEG_TABLE    : the same patterns packed so a nibble can index them
//   SEG_OFF      : pin level for "all segments dark" (pins are active-low)
//   scan_state_t : per-slot phase, BLANK (dead-time) or DRIVE
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Element [n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex7_decode.sv
// ---------------------------------------------------------------------------
// hex7_decode
// Combinational hex nibble to 7-segment pattern lookup.
//   nibble  : 4-bit hex digit
//   pattern : active-high {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a common-anode 7-segment display with
// active-low anodes and segments. Each digit gets a slot of SCAN_DIV clocks;
// the first BLANK_CYC clocks of every slot keep all anodes off to suppress
// ghosting. Displayed data lives in a shadow copy that only changes at slot
// boundaries, so a digit never tears mid-slot.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   value      : hex nibbles, digit i = value[4i+3:4i]
//   dp_in      : decimal point request per digit (1 = lit)
//   digit_en   : per-digit enable (1 = shown)
//   load       : one-cycle strobe capturing value/dp_in/digit_en
//   an         : anode selects, active-low
//   seg        : {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_done : one-cycle pulse after the last digit slot ends
// ---------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                boundary;
  logic                last_digit;
  scan_state_t         state;

  // Pending (written by load) and shadow (displayed) copies
  logic [4*DIGITS-1:0] val_pend_reg;
  logic [DIGITS-1:0]   dp_pend_reg;
  logic [DIGITS-1:0]   en_pend_reg;
  logic                pend_reg;
  logic [4*DIGITS-1:0] val_sh_reg;
  logic [DIGITS-1:0]   dp_sh_reg;
  logic [DIGITS-1:0]   en_sh_reg;

  // Output path
  logic [3:0]          nibs [DIGITS];
  logic [3:0]          nib_cur;
  logic [6:0]          pattern;
  logic                lit;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_reg;
  logic [6:0]          seg_reg;
  logic                dp_reg;
  logic                frame_done_reg;

  assign boundary   = (cnt_reg == CNT_MAX);
  assign last_digit = (idx_reg == IDX_MAX);

  // Phase is a pure function of the slot counter; with no dead-time the
  // whole slot is DRIVE.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign state = DRIVE;
    end else begin : g_blank
      assign state = (cnt_reg < CNT_W'(BLANK_CYC)) ? BLANK : DRIVE;
    end
  endgenerate

  // Slot counter, digit index and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      if (boundary) begin
        cnt_reg <= '0;
        idx_reg <= last_digit ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      frame_done_reg <= boundary && last_digit;
    end
  end

  // Load handling. A load on the boundary cycle goes straight to the shadow
  // so it is not delayed by a whole extra slot; otherwise the latest load is
  // parked in the pending copy until the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_pend_reg <= '0;
      dp_pend_reg  <= '0;
      en_pend_reg  <= '0;
      pend_reg     <= 1'b0;
      val_sh_reg   <= '0;
      dp_sh_reg    <= '0;
      en_sh_reg    <= '0;
    end else begin
      if (load) begin
        val_pend_reg <= value;
        dp_pend_reg  <= dp_in;
        en_pend_reg  <= digit_en;
      end
      if (boundary) begin
        pend_reg <= 1'b0;
        if (load) begin
          val_sh_reg <= value;
          dp_sh_reg  <= dp_in;
          en_sh_reg  <= digit_en;
        end else if (pend_reg) begin
          val_sh_reg <= val_pend_reg;
          dp_sh_reg  <= dp_pend_reg;
          en_sh_reg  <= en_pend_reg;
        end
      end else if (load) begin
        pend_reg <= 1'b1;
      end
    end
  end

  // Select the current digit's nibble from the shadow copy.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nibs[gi] = val_sh_reg[4*gi +: 4];
    end
  endgenerate

  assign nib_cur = nibs[idx_reg];

  hex7_decode u_hex7_decode (
    .nibble  (nib_cur),
    .pattern (pattern)
  );

  // A digit is lit only in DRIVE and when enabled. Segments and dp are also
  // held dark for a disabled digit so the pins are fully quiet, not just the
  // anode.
  assign lit = (state == DRIVE) && en_sh_reg[idx_reg];

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_an
      assign an_next[gi] = ~(lit && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  assign seg_next = lit ? ~pattern : SEG_OFF;
  assign dp_next  = lit ? ~dp_sh_reg[idx_reg] : 1'b1;

  // Registered pins: one cycle behind (cnt, idx).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= '1;
      seg_reg <= SEG_OFF;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with DIGITS=8, SCAN_DIV=8, BLANK_CYC=2
// (8-cycle slots, 64-cycle frames). Expected pin values are hand-computed
// constants; frame_done is expected on every 64th edge after reset release.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_vec = 0;
  int n_bad = 0;
  int edges = 0;   // clock edges since reset release

  // Digit i of 32'h01234567, all enabled, no decimal points
  logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_tab [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS    (8),
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  // One clock, then check all pins; frame_done is due on every 64th edge.
  task automatic cyc(input string tag, input logic [7:0] an_e, input logic [6:0] seg_e,
                     input logic dp_e, input bit chk_seg);
    tick();
    check({tag, ".an"}, 32'(an), 32'(an_e));
    if (chk_seg) begin
      check({tag, ".seg"}, 32'(seg), 32'(seg_e));
      check({tag, ".dp"}, 32'(dp), 32'(dp_e));
    end
    check({tag, ".fd"}, 32'(frame_done), 32'((edges % 64) == 0));
  endtask

  // One full slot: 2 blank cycles then 6 drive cycles.
  task automatic slot(input string tag, input logic [7:0] an_e, input logic [6:0] seg_e,
                      input logic dp_e, input bit chk_seg);
    for (int j = 0; j < 8; j++) begin
      if (j < 2) cyc({tag, ".blank"}, 8'hFF, 7'h7F, 1'b1, 1'b1);
      else       cyc(tag, an_e, seg_e, dp_e, chk_seg);
    end
  endtask

  task automatic to_frame_start();
    while ((edges % 64) != 0) tick();
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] dpi, input logic [7:0] en);
    value = v; dp_in = dpi; digit_en = en; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst.an", 32'(an), 32'h0000_00FF);
    check("rst.seg", 32'(seg), 32'h0000_007F);
    check("rst.dp", 32'(dp), 32'h1);
    check("rst.fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    edges = 0;

    // Dark with no load; frame_done every 64 cycles
    for (int k = 0; k < 200; k++) cyc("idle", 8'hFF, 7'h7F, 1'b1, 1'b1);

    // Load during digit7 slot: 0x18, digits 0/1 enabled, dp on digit1
    to_frame_start();
    repeat (59) tick();
    pulse_load(32'h0000_0018, 8'h02, 8'h03);
    to_frame_start();
    slot("two.d0", 8'hFE, 7'h00, 1'b1, 1'b1);
    slot("two.d1", 8'hFD, 7'h79, 1'b0, 1'b1);
    for (int k = 2; k < 8; k++) slot("two.off", 8'hFF, 7'h7F, 1'b1, 1'b0);

    // All digits, 0x01234567
    repeat (59) tick();
    pulse_load(32'h0123_4567, 8'h00, 8'hFF);
    to_frame_start();
    for (int k = 0; k < 8; k++) slot("scan", an_tab[k], seg_tab[k], 1'b1, 1'b1);

    // Two loads in digit2 slot: A at cnt3, B at cnt5; B wins, shown from digit3
    slot("ab.d0", 8'hFE, 7'h78, 1'b1, 1'b1);
    slot("ab.d1", 8'hFD, 7'h02, 1'b1, 1'b1);
    for (int j = 0; j < 8; j++) begin
      dp_in = 8'h00; digit_en = 8'hFF;
      load = (j == 3) || (j == 5);
      value = (j == 3) ? 32'hFFFF_FFFF : 32'h89AB_CDEF;
      if (j < 2) cyc("ab.d2hold", 8'hFF, 7'h7F, 1'b1, 1'b1);
      else       cyc("ab.d2hold", 8'hFB, 7'h12, 1'b1, 1'b1);
    end
    load = 1'b0;
    slot("ab.d3", 8'hF7, 7'h46, 1'b1, 1'b1);
    slot("ab.d4", 8'hEF, 7'h03, 1'b1, 1'b1);
    slot("ab.d5", 8'hDF, 7'h08, 1'b1, 1'b1);
    slot("ab.d6", 8'hBF, 7'h10, 1'b1, 1'b1);
    slot("ab.d7", 8'h7F, 7'h00, 1'b1, 1'b1);
    slot("ab.d0n", 8'hFE, 7'h0E, 1'b1, 1'b1);
    slot("ab.d1n", 8'hFD, 7'h06, 1'b1, 1'b1);
    slot("ab.d2n", 8'hFB, 7'h21, 1'b1, 1'b1);

    // Load on the boundary cycle of digit3 -> visible in digit4's drive phase
    for (int j = 0; j < 8; j++) begin
      value = 32'h4444_4444; dp_in = 8'hFF; digit_en = 8'hFF;
      load = (j == 7);
      if (j < 2) cyc("byp.d3", 8'hFF, 7'h7F, 1'b1, 1'b1);
      else       cyc("byp.d3", 8'hF7, 7'h46, 1'b1, 1'b1);
    end
    load = 1'b0;
    slot("byp.d4", 8'hEF, 7'h19, 1'b0, 1'b1);

    // Asynchronous reset in the middle of digit5's drive phase
    cyc("ar.pre", 8'hFF, 7'h7F, 1'b1, 1'b1);
    cyc("ar.pre", 8'hFF, 7'h7F, 1'b1, 1'b1);
    cyc("ar.pre", 8'hDF, 7'h19, 1'b0, 1'b1);
    cyc("ar.pre", 8'hDF, 7'h19, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ar.an", 32'(an), 32'h0000_00FF);
    check("ar.seg", 32'(seg), 32'h0000_007F);
    check("ar.dp", 32'(dp), 32'h1);
    check("ar.fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0;

    // Shadow cleared, idx restarted: a load in slot 0 first shows in slot 1
    value = 32'h7654_3210; dp_in = 8'h00; digit_en = 8'hFF;
    for (int j = 0; j < 8; j++) begin
      load = (j == 3);
      cyc("ar.dark", 8'hFF, 7'h7F, 1'b1, 1'b1);
    end
    load = 1'b0;
    slot("ar.d1", 8'hFD, 7'h79, 1'b1, 1'b1);
    slot("ar.d2", 8'hFB, 7'h24, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
